// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the melody player.
//   - note-code constants (rest, C4..B6)
//   - note frequency table and tone half-period helper
//   - player FSM state encoding
//   - rom_data field layout ({dur, note}, note in the low bits)
package song_pkg;

    // Note codes: 1..7 = C..B octave 4, 8..14 octave 5, 15..21 octave 6.
    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_C4   = 5'd1;
    localparam logic [4:0] NOTE_D4   = 5'd2;
    localparam logic [4:0] NOTE_E4   = 5'd3;
    localparam logic [4:0] NOTE_F4   = 5'd4;
    localparam logic [4:0] NOTE_G4   = 5'd5;
    localparam logic [4:0] NOTE_A4   = 5'd6;
    localparam logic [4:0] NOTE_B4   = 5'd7;
    localparam logic [4:0] NOTE_C5   = 5'd8;
    localparam logic [4:0] NOTE_D5   = 5'd9;
    localparam logic [4:0] NOTE_E5   = 5'd10;
    localparam logic [4:0] NOTE_F5   = 5'd11;
    localparam logic [4:0] NOTE_G5   = 5'd12;
    localparam logic [4:0] NOTE_A5   = 5'd13;
    localparam logic [4:0] NOTE_B5   = 5'd14;
    localparam logic [4:0] NOTE_C6   = 5'd15;
    localparam logic [4:0] NOTE_D6   = 5'd16;
    localparam logic [4:0] NOTE_E6   = 5'd17;
    localparam logic [4:0] NOTE_F6   = 5'd18;
    localparam logic [4:0] NOTE_G6   = 5'd19;
    localparam logic [4:0] NOTE_A6   = 5'd20;
    localparam logic [4:0] NOTE_B6   = 5'd21;
    localparam int         NOTE_MAX  = 21;

    // Divider width: C4 at 100 MHz needs 190839 < 2**18.
    localparam int TONE_CNT_W = 18;

    // rom_data layout: note in the low bits, duration directly above it.
    localparam int NOTE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    // Frequency in Hz of a note code; 0 for rest and unused codes.
    function automatic int note_hz(input int note);
        int base_hz;
        int idx;
        if ((note < 32'sd1) || (note > NOTE_MAX)) begin
            return 32'sd0;
        end
        idx = (note - 32'sd1) % 32'sd7;
        case (idx)
            32'sd0:  base_hz = 32'sd262;
            32'sd1:  base_hz = 32'sd294;
            32'sd2:  base_hz = 32'sd330;
            32'sd3:  base_hz = 32'sd349;
            32'sd4:  base_hz = 32'sd392;
            32'sd5:  base_hz = 32'sd440;
            32'sd6:  base_hz = 32'sd494;
            default: base_hz = 32'sd0;
        endcase
        // Each octave above 4 doubles the frequency.
        return base_hz << ((note - 32'sd1) / 32'sd7);
    endfunction

    // Clock cycles per half tone period; 0 means "silent".
    function automatic logic [TONE_CNT_W-1:0] half_period(input int clk_hz, input int note);
        int hz;
        hz = note_hz(note);
        if (hz == 32'sd0) begin
            return '0;
        end
        return TONE_CNT_W'(clk_hz / (32'sd2 * hz));
    endfunction

endpackage

// File: rtl/song_player_tone_gen.sv
// tone_gen: square-wave generator for the current note.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   note  - note code to sound (0 or >21 = silent)
//   wave  - square wave, 50% duty, period 2*half_period(CLK_HZ, note)
// Any change of note restarts the divider from phase 0 with wave low.
module tone_gen
    import song_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int NOTE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] note,
    output logic              wave
);

    logic [TONE_CNT_W-1:0] hp_tab_s [2**NOTE_W];
    logic [TONE_CNT_W-1:0] half_s;
    logic [TONE_CNT_W-1:0] cnt_r;
    logic [NOTE_W-1:0]     note_q_r;
    logic                  wave_r;

    // Half-period lookup table, folded to constants at elaboration.
    for (genvar i = 0; i < 2**NOTE_W; i++) begin : g_hp
        assign hp_tab_s[i] = half_period(CLK_HZ, i);
    end

    assign half_s = hp_tab_s[note];
    assign wave   = wave_r;

    // Divider counter, note-change restart and wave toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            note_q_r <= '0;
            wave_r   <= 1'b0;
        end else if (note != note_q_r) begin
            note_q_r <= note;
            cnt_r    <= '0;
            wave_r   <= 1'b0;
        end else if (half_s == '0) begin
            cnt_r    <= '0;
            wave_r   <= 1'b0;
        end else if (cnt_r == (half_s - TONE_CNT_W'(1))) begin
            cnt_r    <= '0;
            wave_r   <= ~wave_r;
        end else begin
            cnt_r    <= cnt_r + TONE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/song_player.sv
// song_player: plays a melody from a registered note ROM on a buzzer.
//   clk, rst_n - system clock, asynchronous active-low reset
//   beat       - slow beat tick; only its rising edge counts
//   start      - pulse, begins playback at address 0 (ignored unless idle)
//   stop       - pulse, aborts playback (wins over start and beat)
//   rom_addr   - ROM read address
//   rom_data   - {dur, note}, valid one cycle after rom_addr changes
//   buzzer     - square-wave tone
//   playing    - high from LOAD of the first entry until the song ends
//   cur_note   - note currently sounding, 0 = rest
//   done       - one-cycle pulse on normal completion
module song_player
    import song_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SONG_LEN = 32,
    parameter int NOTE_W   = 5,
    parameter int DUR_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        beat,
    input  logic                        start,
    input  logic                        stop,
    output logic [$clog2(SONG_LEN)-1:0] rom_addr,
    input  logic [DUR_W+NOTE_W-1:0]     rom_data,
    output logic                        buzzer,
    output logic                        playing,
    output logic [NOTE_W-1:0]           cur_note,
    output logic                        done
);

    localparam int                ADDR_W    = $clog2(SONG_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    state_t             state_r;
    logic               beat_q_r;
    logic [DUR_W-1:0]   beat_cnt_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [NOTE_W-1:0]  cur_note_r;
    logic               playing_r;
    logic               done_r;

    logic               beat_edge_s;
    logic [NOTE_W-1:0]  rom_note_s;
    logic [DUR_W-1:0]   rom_dur_s;
    logic               wave_s;

    assign beat_edge_s = beat & ~beat_q_r;
    assign rom_note_s  = rom_data[NOTE_LSB +: NOTE_W];
    assign rom_dur_s   = rom_data[NOTE_LSB + NOTE_W +: DUR_W];

    assign rom_addr = rom_addr_r;
    assign cur_note = cur_note_r;
    assign playing  = playing_r;
    assign done     = done_r;
    // Gating with playing silences the pin in the very cycle stop/done take
    // effect; the tone divider itself only notices the note change a cycle later.
    assign buzzer   = wave_s & playing_r;

    // Beat edge detect, playback FSM, address and duration counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            beat_q_r   <= 1'b0;
            beat_cnt_r <= '0;
            rom_addr_r <= '0;
            cur_note_r <= '0;
            playing_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            beat_q_r <= beat;
            done_r   <= 1'b0;
            if (stop) begin
                state_r    <= ST_IDLE;
                cur_note_r <= '0;
                playing_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            rom_addr_r <= '0;
                            state_r    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        // rom_data for rom_addr_r becomes valid in LOAD.
                        playing_r <= 1'b1;
                        state_r   <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (rom_dur_s == '0) begin
                            // End marker.
                            done_r     <= 1'b1;
                            cur_note_r <= '0;
                            playing_r  <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            cur_note_r <= rom_note_s;
                            beat_cnt_r <= rom_dur_s;
                            state_r    <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (beat_edge_s) begin
                            beat_cnt_r <= beat_cnt_r - DUR_W'(1);
                            if (beat_cnt_r == DUR_W'(1)) begin
                                if (rom_addr_r == LAST_ADDR) begin
                                    done_r     <= 1'b1;
                                    cur_note_r <= '0;
                                    playing_r  <= 1'b0;
                                    state_r    <= ST_IDLE;
                                end else begin
                                    // cur_note keeps sounding while the next entry is fetched.
                                    rom_addr_r <= rom_addr_r + ADDR_W'(1);
                                    state_r    <= ST_FETCH;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        cur_note_r <= '0;
                        playing_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    tone_gen #(
        .CLK_HZ (CLK_HZ),
        .NOTE_W (NOTE_W)
    ) u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .note  (cur_note_r),
        .wave  (wave_s)
    );

endmodule

// File: tb/tb_song_player.sv
// Testbench for song_player: behavioural model + per-cycle compare,
// directed scenarios with hand-computed expectations, and random songs.
module tb_song_player;

    localparam int CLK_HZ = 1_000_000;
    localparam int LEN    = 4;
    localparam int NW     = 5;
    localparam int DW     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beat = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] rom_addr;
    logic [7:0] rom_data;
    logic       buzzer;
    logic       playing;
    logic [4:0] cur_note;
    logic       done;

    logic [7:0] rom [LEN];

    int n_vec = 0;
    int n_err = 0;

    int beat_period = 5000;
    int beat_hi     = 3;
    bit beat_en     = 1'b0;

    // Behavioural model state.
    int cyc, m_addr, m_delay, m_beats, m_note, m_t, p_note, p_t;
    bit m_active, m_play, m_done, m_bprev;

    // Directed-scenario observations.
    int notes[$];
    int done_cnt, done_addr, done_play;

    song_player #(
        .CLK_HZ   (CLK_HZ),
        .SONG_LEN (LEN),
        .NOTE_W   (NW),
        .DUR_W    (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat     (beat),
        .start    (start),
        .stop     (stop),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .buzzer   (buzzer),
        .playing  (playing),
        .cur_note (cur_note),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [7:0] ent(input int dur, input int note);
        logic [2:0] d;
        logic [4:0] n;
        d = 3'(dur);
        n = 5'(note);
        return {d, n};
    endfunction

    // Half period straight from the note-frequency rules.
    function automatic int hp_of(input int n);
        int base[7] = '{262, 294, 330, 349, 392, 440, 494};
        if (n < 1 || n > 21) return 0;
        return CLK_HZ / (2 * (base[(n - 1) % 7] << ((n - 1) / 7)));
    endfunction

    // Square wave of a note that appeared at cycle t0 (restarts low at t0+1).
    function automatic bit wave_of(input int n, input int t0, input int t);
        int hp;
        hp = hp_of(n);
        if (hp == 0 || t <= t0) return 1'b0;
        return 1'(((t - t0 - 1) / hp) % 2);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat source: beat_hi cycles high every beat_period cycles.
    initial begin : beat_src
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph >= beat_period) ph = 0;
            beat = beat_en && (ph < beat_hi);
        end
    end

    // Behavioural model: song position, beats left, fetch delay.
    initial begin : model
        bit edge_b;
        int nn;
        logic [7:0] e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; m_addr = 0; m_delay = 0; m_beats = 0;
                m_note = 0; m_t = 0; p_note = 0; p_t = 0;
                m_active = 1'b0; m_play = 1'b0; m_done = 1'b0; m_bprev = 1'b0;
            end else begin
                cyc++;
                edge_b  = beat && !m_bprev;
                m_bprev = beat;
                m_done  = 1'b0;
                nn      = m_note;
                if (stop) begin
                    m_active = 1'b0; m_play = 1'b0; nn = 0;
                end else if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1; m_addr = 0; m_delay = 2;
                    end
                end else if (m_delay > 0) begin
                    m_delay--;
                    if (m_delay == 1) begin
                        m_play = 1'b1;
                    end else begin
                        e = rom[m_addr];
                        if (e[7:5] == 3'd0) begin
                            m_done = 1'b1; m_active = 1'b0; m_play = 1'b0; nn = 0;
                        end else begin
                            nn = int'(e[4:0]); m_beats = int'(e[7:5]);
                        end
                    end
                end else if (edge_b) begin
                    m_beats--;
                    if (m_beats == 0) begin
                        if (m_addr == LEN - 1) begin
                            m_done = 1'b1; m_active = 1'b0; m_play = 1'b0; nn = 0;
                        end else begin
                            m_addr++; m_delay = 2;
                        end
                    end
                end
                if (nn != m_note) begin
                    p_note = m_note; p_t = m_t; m_note = nn; m_t = cyc;
                end
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    initial begin : compare
        logic [9:0] act_v, exp_v;
        bit eb;
        forever begin
            @(negedge clk);
            eb = (cyc > m_t) ? wave_of(m_note, m_t, cyc) : wave_of(p_note, p_t, cyc);
            eb = eb & m_play;
            exp_v = {2'(m_addr), 5'(m_note), m_play, m_done, eb};
            act_v = {rom_addr, cur_note, playing, done, buzzer};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got addr=%0d note=%0d play=%0b done=%0b buz=%0b, expected addr=%0d note=%0d play=%0b done=%0b buz=%0b",
                         $time, act_v[9:8], act_v[7:3], act_v[2], act_v[1], act_v[0],
                         exp_v[9:8], exp_v[7:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    // Start a song and watch it to completion (+20 cycles for stray dones).
    task automatic run_song(input string name, input int max_cyc);
        int prev, tail;
        notes.delete();
        done_cnt = 0; done_addr = -1; done_play = -1;
        prev = int'(cur_note);
        tail = -1;
        pulse_start();
        for (int k = 0; k < max_cyc && tail != 0; k++) begin
            @(negedge clk);
            if (int'(cur_note) != prev) begin
                notes.push_back(int'(cur_note));
                prev = int'(cur_note);
            end
            if (done) begin
                done_cnt++; done_addr = int'(rom_addr); done_play = int'(playing);
            end
            if (tail > 0) tail--;
            else if (tail < 0 && done) tail = 20;
        end
        chk({name, "_completed"}, int'(tail == 0), 1);
    endtask

    initial begin : main
        int exp1[4] = '{6, 8, 5, 0};
        int exp2[5] = '{1, 2, 3, 4, 0};
        int rises[$], falls[$];
        int c, k;
        bit last;

        for (int i = 0; i < LEN; i++) rom[i] = 8'h00;
        #23 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_note", int'(cur_note), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_addr", int'(rom_addr), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_done", int'(done), 0);

        // Song 1: A4 x1, C5 x2, G4 x1, end marker. 3-cycle beats, 5000 apart.
        rom[0] = ent(1, 6); rom[1] = ent(2, 8); rom[2] = ent(1, 5); rom[3] = ent(0, 3);
        beat_period = 5000; beat_hi = 3; beat_en = 1'b1;
        run_song("song1", 30000);
        chk("song1_changes", notes.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < notes.size()) chk("song1_note", notes[i], exp1[i]);
        chk("song1_done_cnt", done_cnt, 1);
        chk("song1_done_addr", done_addr, 3);
        chk("song1_done_playing", done_play, 0);

        // Tone: A4 held (beats off), measure three full periods.
        rom[0] = ent(1, 6); rom[1] = ent(0, 0);
        beat_en = 1'b0;
        pulse_start();
        for (k = 0; k < 50 && cur_note != 5'd6; k++) @(negedge clk);
        chk("tone_note_a4", int'(cur_note), 6);
        c = 0; last = buzzer;
        while (rises.size() < 4 && c < 12000) begin
            @(negedge clk); c++;
            if (buzzer && !last) rises.push_back(c);
            if (!buzzer && last && rises.size() > 0) falls.push_back(c);
            last = buzzer;
        end
        chk("tone_rises", rises.size(), 4);
        if (rises.size() == 4 && falls.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("tone_period", rises[i + 1] - rises[i], 2272);
                chk("tone_high", falls[i] - rises[i], 1136);
            end
        end
        beat_period = 3000; beat_en = 1'b1;
        for (k = 0; k < 8000 && !done; k++) @(negedge clk);
        chk("tone_song_done", int'(done), 1);
        repeat (5) @(negedge clk);

        // Stop mid-note at address 1 while the buzzer is high.
        rom[0] = ent(1, 6); rom[1] = ent(2, 8); rom[2] = ent(1, 5); rom[3] = ent(0, 0);
        done_cnt = 0;
        pulse_start();
        for (k = 0; k < 20000 && !(cur_note == 5'd8 && buzzer); k++) @(negedge clk);
        chk("stop_reached_c5_high", int'(cur_note == 5'd8 && buzzer), 1);
        chk("stop_addr", int'(rom_addr), 1);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("stop_note", int'(cur_note), 0);
        chk("stop_playing", int'(playing), 0);
        chk("stop_buzzer", int'(buzzer), 0);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("stop_no_done", done_cnt, 0);
        chk("stop_stays_idle", int'(playing), 0);
        pulse_start();
        for (k = 0; k < 10 && cur_note == 5'd0; k++) @(negedge clk);
        chk("replay_note", int'(cur_note), 6);
        chk("replay_addr", int'(rom_addr), 0);

        // Asynchronous reset mid-PLAY, between clock edges.
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_note", int'(cur_note), 0);
        chk("areset_playing", int'(playing), 0);
        chk("areset_buzzer", int'(buzzer), 0);
        chk("areset_addr", int'(rom_addr), 0);
        chk("areset_done", int'(done), 0);
        repeat (3) @(negedge clk);
        #13 rst_n = 1'b1;
        repeat (4000) @(negedge clk);
        chk("post_reset_idle_note", int'(cur_note), 0);
        chk("post_reset_idle_playing", int'(playing), 0);
        pulse_start();
        for (k = 0; k < 10 && cur_note == 5'd0; k++) @(negedge clk);
        chk("post_reset_start_note", int'(cur_note), 6);
        pulse_stop();
        repeat (5) @(negedge clk);

        // No end marker: finishes after the last address, no wrap.
        rom[0] = ent(1, 1); rom[1] = ent(1, 2); rom[2] = ent(1, 3); rom[3] = ent(1, 4);
        run_song("nomark", 20000);
        chk("nomark_changes", notes.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < notes.size()) chk("nomark_note", notes[i], exp2[i]);
        chk("nomark_done_cnt", done_cnt, 1);
        chk("nomark_done_addr", done_addr, 3);
        chk("nomark_addr_hold", int'(rom_addr), 3);

        // Random songs with random beat spacing, stray starts and stops.
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < LEN; i++)
                rom[i] = ent(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7),
                             $urandom_range(0, 31));
            beat_period = $urandom_range(15, 60);
            beat_hi     = $urandom_range(1, 3);
            pulse_start();
            for (k = 0; k < 3000; k++) begin
                @(negedge clk);
                c = $urandom_range(0, 999);
                stop  = (c < 2);
                start = (c >= 2 && c < 8);
                if (!m_active && k > 10) break;
            end
            @(negedge clk); stop = 1'b0; start = 1'b0;
            pulse_stop();
            repeat (3) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
